// File: rtl/div_sequencer_if.sv
// Handshake/operand bundle between the pipeline and the iterative divider.
// The remainder signal exists only when DIV_REM_EN is defined.
interface div_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic             abort;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic             div_by_zero;
`ifdef DIV_REM_EN
    logic [WIDTH-1:0] remainder;
`endif

    modport master (
        output start, is_signed, abort, dividend, divisor,
        input  stall, busy, done, quotient, div_by_zero
`ifdef DIV_REM_EN
        , input remainder
`endif
    );

    modport slave (
        input  start, is_signed, abort, dividend, divisor,
        output stall, busy, done, quotient, div_by_zero
`ifdef DIV_REM_EN
        , output remainder
`endif
    );
endinterface

// File: rtl/div_sequencer.sv
// Radix-2 restoring SDIV/UDIV sequencer, one quotient bit per cycle, stalls the pipeline while busy.
// Define DIV_REM_EN to expose the signed remainder output.
module div_sequencer #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    div_sequencer_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIXUP, DONE} state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             stall_c;

    logic [WIDTH-1:0] a_r, b_r;
    logic             sgn_r;
    logic [WIDTH-1:0] q_r, r_r, d_r;
    logic             neg_q, neg_r;
    logic [WIDTH:0]   r_sh, r_dif;
    logic             r_ge;

    logic [WIDTH-1:0] quotient_r;
    logic             dbz_r;
`ifdef DIV_REM_EN
    logic [WIDTH-1:0] remainder_r;
`endif

    // Conditional two's-complement negate; used for both abs() and sign fix-up.
    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign accept = (state == IDLE) && bus.start && !bus.abort;

    // One bit wider than the operands so an unsigned divisor near 2^WIDTH compares correctly.
    assign r_sh  = {r_r, q_r[WIDTH-1]};
    assign r_dif = r_sh - {1'b0, d_r};
    assign r_ge  = (r_sh >= {1'b0, d_r});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == PREP)
                cnt <= '0;
            else if (state == ITER)
                cnt <= cnt + CW'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = PREP;
                    stall_c   = 1'b1;
                end
            end
            PREP: begin
                state_nxt = (b_r == '0) ? DONE : ITER;
                stall_c   = 1'b1;
            end
            ITER: begin
                if (cnt == CW'(WIDTH - 1))
                    state_nxt = FIXUP;
                stall_c = 1'b1;
            end
            FIXUP: begin
                state_nxt = DONE;
                stall_c   = 1'b1;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort)
            state_nxt = IDLE;
    end

    // Working datapath: no reset needed, every field is loaded before it is used.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r   <= bus.dividend;
            b_r   <= bus.divisor;
            sgn_r <= bus.is_signed;
        end
        if (state == PREP) begin
            q_r   <= neg_if(a_r, sgn_r & a_r[WIDTH-1]);
            d_r   <= neg_if(b_r, sgn_r & b_r[WIDTH-1]);
            r_r   <= '0;
            neg_q <= sgn_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
            neg_r <= sgn_r & a_r[WIDTH-1];
        end else if (state == ITER) begin
            r_r <= r_ge ? r_dif[WIDTH-1:0] : r_sh[WIDTH-1:0];
            q_r <= {q_r[WIDTH-2:0], r_ge};
        end
    end

    // Result registers change only on a completed op, so an abort leaves them intact.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quotient_r  <= '0;
            dbz_r       <= 1'b0;
`ifdef DIV_REM_EN
            remainder_r <= '0;
`endif
        end else if (!bus.abort) begin
            if (state == PREP && b_r == '0) begin
                quotient_r  <= '0;
                dbz_r       <= 1'b1;
`ifdef DIV_REM_EN
                remainder_r <= a_r;
`endif
            end else if (state == FIXUP) begin
                quotient_r  <= neg_if(q_r, neg_q);
                dbz_r       <= 1'b0;
`ifdef DIV_REM_EN
                remainder_r <= neg_if(r_r, neg_r);
`endif
            end
        end
    end

    assign bus.stall       = stall_c;
    assign bus.busy        = (state != IDLE);
    assign bus.done        = (state == DONE);
    assign bus.quotient    = quotient_r;
    assign bus.div_by_zero = dbz_r;
`ifdef DIV_REM_EN
    assign bus.remainder   = remainder_r;
`endif
endmodule

// File: tb/tb_div_sequencer.sv
// Directed testbench for div_sequencer (WIDTH=32); remainder checks apply when DIV_REM_EN is defined.
module tb_div_sequencer;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;

    div_sequencer_if #(.WIDTH(32)) bus ();

    div_sequencer #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    // Issues one op; dc = cycle with done (-1 if never), sc = cycles with stall high.
    // At cycle 'poke' a stray start with different operands is driven.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output int dc, output int sc);
        dc = -1;
        sc = 0;
        bus.is_signed = sg;
        bus.dividend  = a;
        bus.divisor   = b;
        bus.start     = 1'b1;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (bus.stall) sc++;
            if (bus.done) begin
                dc = c;
                break;
            end
            next_cyc();
            bus.start = (c + 1 == poke);
            if (c + 1 == poke) begin
                bus.dividend = 32'd99;
                bus.divisor  = 32'd1;
            end
        end
        bus.start = 1'b0;
    endtask

    int dc, sc, ndone, d1, d2;
    logic [31:0] q1, q2;

    initial begin
        n_chk = 0;
        n_pass = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.is_signed = 1'b0;
        bus.abort = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_quot", bus.quotient, 0);
        check("rst_dbz", bus.div_by_zero, 0);
`ifdef DIV_REM_EN
        check("rst_rem", bus.remainder, 0);
`endif
        #10 reset = 1'b1;
        next_cyc();

        // UDIV 100/7
        run_op(1'b0, 32'd100, 32'd7, -1, dc, sc);
        check("u100_7_lat", dc, 35);
        check("u100_7_stall", sc, 35);
        check("u100_7_stall_done", bus.stall, 0);
        check("u100_7_q", bus.quotient, 14);
        check("u100_7_dbz", bus.div_by_zero, 0);
`ifdef DIV_REM_EN
        check("u100_7_r", bus.remainder, 2);
`endif
        next_cyc();
        check("u100_7_idle", bus.done, 0);

        run_op(1'b1, 32'hFFFF_FF9C, 32'd7, -1, dc, sc);
        check("sm100_7_q", bus.quotient, 32'hFFFF_FFF2);
`ifdef DIV_REM_EN
        check("sm100_7_r", bus.remainder, 32'hFFFF_FFFE);
`endif
        next_cyc();
        run_op(1'b1, 32'd100, 32'hFFFF_FFF9, -1, dc, sc);
        check("s100_m7_q", bus.quotient, 32'hFFFF_FFF2);
`ifdef DIV_REM_EN
        check("s100_m7_r", bus.remainder, 32'd2);
`endif
        next_cyc();
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, dc, sc);
        check("smin_m1_q", bus.quotient, 32'h8000_0000);
        check("smin_m1_dbz", bus.div_by_zero, 0);
`ifdef DIV_REM_EN
        check("smin_m1_r", bus.remainder, 0);
`endif
        next_cyc();
        run_op(1'b0, 32'hFFFF_FFFF, 32'd2, -1, dc, sc);
        check("umax_2_q", bus.quotient, 32'h7FFF_FFFF);
`ifdef DIV_REM_EN
        check("umax_2_r", bus.remainder, 1);
`endif

        // Divide by zero, then recovery
        next_cyc();
        run_op(1'b0, 32'd5, 32'd0, -1, dc, sc);
        check("dbz_lat", dc, 2);
        check("dbz_stall", sc, 2);
        check("dbz_q", bus.quotient, 0);
        check("dbz_flag", bus.div_by_zero, 1);
`ifdef DIV_REM_EN
        check("dbz_r", bus.remainder, 5);
`endif
        next_cyc();
        run_op(1'b0, 32'd9, 32'd3, -1, dc, sc);
        check("dbz_clr_flag", bus.div_by_zero, 0);
        check("dbz_clr_q", bus.quotient, 3);

        // Stray start with new operands while busy is ignored
        next_cyc();
        run_op(1'b0, 32'd50, 32'd5, 5, dc, sc);
        check("poke_lat", dc, 35);
        check("poke_q", bus.quotient, 10);
        next_cyc();
        #1;
        check("poke_no_queue", bus.busy, 0);

        // Abort in cycle 10
        next_cyc();
        bus.is_signed = 1'b0;
        bus.dividend = 32'd1000;
        bus.divisor = 32'd10;
        bus.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            next_cyc();
            bus.start = 1'b0;
            if (c == 10) bus.abort = 1'b1;
        end
        next_cyc();
        bus.abort = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_stall", bus.stall, 0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            next_cyc();
            if (bus.done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        check("abort_q_held", bus.quotient, 10);

        // Abort together with start in IDLE drops the start
        bus.dividend = 32'd8;
        bus.divisor = 32'd2;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        #1;
        check("abort_start_stall", bus.stall, 0);
        next_cyc();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        #1;
        check("abort_start_busy", bus.busy, 0);

        // Asynchronous reset mid-ITER
        next_cyc();
        bus.dividend = 32'd1000;
        bus.divisor = 32'd3;
        bus.start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            next_cyc();
            bus.start = 1'b0;
        end
        #2 reset = 1'b0;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_stall", bus.stall, 0);
        check("arst_q", bus.quotient, 0);
        #1 reset = 1'b1;
        next_cyc();
        run_op(1'b0, 32'd77, 32'd7, -1, dc, sc);
        check("arst_next_lat", dc, 35);
        check("arst_next_q", bus.quotient, 11);

        // Back-to-back with start held high
        next_cyc();
        bus.is_signed = 1'b0;
        bus.dividend = 32'd200;
        bus.divisor = 32'd10;
        bus.start = 1'b1;
        d1 = -1;
        d2 = -1;
        q1 = '0;
        q2 = '0;
        for (int c = 0; c < 90; c++) begin
            #1;
            if (bus.done) begin
                if (d1 < 0) begin
                    d1 = c;
                    q1 = bus.quotient;
                    bus.dividend = 32'd300;
                    bus.divisor = 32'd3;
                end else begin
                    d2 = c;
                    q2 = bus.quotient;
                    break;
                end
            end
            next_cyc();
        end
        bus.start = 1'b0;
        check("b2b_done1", d1, 35);
        check("b2b_done2", d2, 71);
        check("b2b_q1", q1, 20);
        check("b2b_q2", q2, 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
